// File: rtl/seq_num_gen_multi_pkg.sv
// Shared types, entry-state encodings and relative-age helper for the sequence-number generator.
// Latency: none (declarations and a pure combinational function).
// Backpressure: not applicable.
package seq_num_pkg;

    localparam int SEQ_NUM_BITS = 5;
    // Wide enough for any practical ring; ages are masked back down to the ring width.
    localparam int SEQ_AGE_BITS = 16;

    typedef logic [SEQ_NUM_BITS-1:0] seq_num_t;

    localparam logic SEQ_FREE  = 1'b0;
    localparam logic SEQ_ALLOC = 1'b1;

    // Distance of num from tail around a ring of 2**bits entries (0 = oldest).
    function automatic logic [SEQ_AGE_BITS-1:0] seq_rel_age(
        input logic [SEQ_AGE_BITS-1:0] num,
        input logic [SEQ_AGE_BITS-1:0] tail,
        input int                      bits
    );
        logic [SEQ_AGE_BITS-1:0] mask;
        mask = (SEQ_AGE_BITS'(1) << bits) - SEQ_AGE_BITS'(1);
        return (num - tail) & mask;
    endfunction

endpackage

// File: rtl/seq_num_gen_multi_age_cmp.sv
// Relative-age comparator: a_younger = age(num_a) > age(num_b), ages measured from tail.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: num_a, num_b, tail (p_bits each) in; a_younger out.
module seq_rel_age_cmp
    import seq_num_pkg::*;
#(
    parameter int p_bits = SEQ_NUM_BITS
) (
    input  logic [p_bits-1:0] num_a,
    input  logic [p_bits-1:0] num_b,
    input  logic [p_bits-1:0] tail,
    output logic              a_younger
);

    logic [SEQ_AGE_BITS-1:0] age_a;
    logic [SEQ_AGE_BITS-1:0] age_b;

    assign age_a     = seq_rel_age(SEQ_AGE_BITS'(num_a), SEQ_AGE_BITS'(tail), p_bits);
    assign age_b     = seq_rel_age(SEQ_AGE_BITS'(num_b), SEQ_AGE_BITS'(tail), p_bits);
    assign a_younger = age_a > age_b;

endmodule

// File: rtl/seq_num_gen_multi.sv
// Superscalar in-order sequence-number allocator with commit free, squash rewind and tail reclaim.
// Latency: allocation outputs are combinational (squash bypass); frees land at the edge, reclaim a cycle later.
// Backpressure: lanes fire as a val&rdy prefix from lane 0; all alloc_val drop while N-1 numbers are in flight.
// Ports: clk, rst_n (async active-low); alloc_seq_num/alloc_val out, alloc_rdy in (per alloc lane);
//        commit_val/commit_seq_num in (per commit lane); squash_val/squash_seq_num in.
//        Optional SEQ_NUM_GEN_MULTI_OCC_EN adds outputs occupancy (registered in-flight count) and full.
module seq_num_gen_multi
    import seq_num_pkg::*;
#(
    parameter int p_seq_num_bits  = SEQ_NUM_BITS,
    parameter int p_alloc_width   = 2,
    parameter int p_commit_width  = 2,
    parameter int p_reclaim_width = 4
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    output logic [p_alloc_width-1:0][p_seq_num_bits-1:0]   alloc_seq_num,
    output logic [p_alloc_width-1:0]                       alloc_val,
    input  logic [p_alloc_width-1:0]                       alloc_rdy,
    input  logic [p_commit_width-1:0]                      commit_val,
    input  logic [p_commit_width-1:0][p_seq_num_bits-1:0]  commit_seq_num,
    input  logic                                           squash_val,
    input  logic [p_seq_num_bits-1:0]                      squash_seq_num
`ifdef SEQ_NUM_GEN_MULTI_OCC_EN
    ,
    output logic [p_seq_num_bits:0]                        occupancy,
    output logic                                           full
`endif
);

    localparam int N = 1 << p_seq_num_bits;
    typedef logic [p_seq_num_bits-1:0] ptr_t;

    ptr_t head, tail, head_next, tail_next;
    ptr_t base, inflight, inflight_base;
    ptr_t fire_cnt, reclaim_cnt;
    logic [N-1:0] state_q, state_d;
    logic [p_alloc_width-1:0] fire;
    logic [N-1:0] squash_younger;
    logic [p_reclaim_width-1:0] reclaim_in_flight;

    // A squash rewinds the allocation base in the same cycle so fetch restarts right behind it.
    assign base          = squash_val ? squash_seq_num + ptr_t'(1) : head;
    assign inflight      = head - tail;
    assign inflight_base = base - tail;

    always_comb begin
        for (int k = 0; k < p_alloc_width; k++) begin
            alloc_seq_num[k] = base + ptr_t'(k);
            alloc_val[k]     = (int'(inflight_base) + k + 1) <= (N - 1);
        end
    end

    // Only a contiguous run from lane 0 may fire; a stalled lane blocks all later ones.
    always_comb begin
        logic going;
        going    = 1'b1;
        fire     = '0;
        fire_cnt = '0;
        for (int k = 0; k < p_alloc_width; k++) begin
            going   = going & alloc_val[k] & alloc_rdy[k];
            fire[k] = going;
            if (going) fire_cnt = fire_cnt + ptr_t'(1);
        end
    end

    assign head_next = base + fire_cnt;

    for (genvar i = 0; i < N; i++) begin : g_squash_cmp
        seq_rel_age_cmp #(.p_bits(p_seq_num_bits)) u_cmp (
            .num_a     (ptr_t'(i)),
            .num_b     (squash_seq_num),
            .tail      (tail),
            .a_younger (squash_younger[i])
        );
    end

    // Slot tail+r is still in flight when the (post-squash) base is younger than it.
    for (genvar r = 0; r < p_reclaim_width; r++) begin : g_reclaim_cmp
        seq_rel_age_cmp #(.p_bits(p_seq_num_bits)) u_cmp (
            .num_a     (base),
            .num_b     (tail + ptr_t'(r)),
            .tail      (tail),
            .a_younger (reclaim_in_flight[r])
        );
    end

    // Reclaim looks at registered state only, so a free written this edge is passed next cycle.
    always_comb begin
        logic run;
        run         = 1'b1;
        reclaim_cnt = '0;
        for (int r = 0; r < p_reclaim_width; r++) begin
            run = run & reclaim_in_flight[r] & (state_q[tail + ptr_t'(r)] == SEQ_FREE);
            if (run) reclaim_cnt = reclaim_cnt + ptr_t'(1);
        end
    end

    assign tail_next = tail + reclaim_cnt;

    // The squash frees the old younger occupants; a slot re-issued behind the squash in the
    // same cycle belongs to the new instruction and must come out ALLOC.
    always_comb begin
        logic commit_hit;
        logic alloc_hit;
        state_d = state_q;
        for (int i = 0; i < N; i++) begin
            commit_hit = 1'b0;
            alloc_hit  = 1'b0;
            for (int j = 0; j < p_commit_width; j++) begin
                if (commit_val[j] && commit_seq_num[j] == ptr_t'(i)) commit_hit = 1'b1;
            end
            for (int k = 0; k < p_alloc_width; k++) begin
                if (fire[k] && alloc_seq_num[k] == ptr_t'(i)) alloc_hit = 1'b1;
            end
            if (commit_hit)                              state_d[i] = SEQ_FREE;
            else if (alloc_hit)                          state_d[i] = SEQ_ALLOC;
            else if (squash_val && squash_younger[i])    state_d[i] = SEQ_FREE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            state_q <= {N{SEQ_FREE}};
        end else begin
            head    <= head_next;
            tail    <= tail_next;
            state_q <= state_d;
        end
    end

`ifdef SEQ_NUM_GEN_MULTI_OCC_EN
    ptr_t inflight_next;
    assign inflight_next = head_next - tail_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occupancy <= '0;
        else        occupancy <= {1'b0, inflight_next};
    end

    assign full = occupancy == (p_seq_num_bits+1)'(N - 1);
`endif

`ifndef SYNTHESIS
    ptr_t squash_age;
    assign squash_age = squash_seq_num - tail;

    a_squash_in_flight: assert property (@(posedge clk) disable iff (!rst_n)
        squash_val |-> (squash_age < inflight))
        else $error("squash of a sequence number that is not in flight");
`endif

endmodule

// File: tb/tb_seq_num_gen_multi.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
// Latency: not applicable.
// Backpressure: bench drives alloc_rdy randomly and in fixed patterns.
module tb_seq_num_gen_multi;

    localparam int W  = 5;
    localparam int N  = 32;
    localparam int AW = 2;
    localparam int CW = 2;
    localparam int RW = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [AW-1:0][W-1:0]   alloc_seq_num;
    logic [AW-1:0]          alloc_val;
    logic [AW-1:0]          alloc_rdy;
    logic [CW-1:0]          commit_val;
    logic [CW-1:0][W-1:0]   commit_seq_num;
    logic                   squash_val;
    logic [W-1:0]           squash_seq_num;
`ifdef SEQ_NUM_GEN_MULTI_OCC_EN
    logic [W:0]             occupancy;
    logic                   full;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_num_gen_multi #(
        .p_seq_num_bits  (W),
        .p_alloc_width   (AW),
        .p_commit_width  (CW),
        .p_reclaim_width (RW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alloc_seq_num  (alloc_seq_num),
        .alloc_val      (alloc_val),
        .alloc_rdy      (alloc_rdy),
        .commit_val     (commit_val),
        .commit_seq_num (commit_seq_num),
        .squash_val     (squash_val),
        .squash_seq_num (squash_seq_num)
`ifdef SEQ_NUM_GEN_MULTI_OCC_EN
        ,
        .occupancy      (occupancy),
        .full           (full)
`endif
    );

    // Model: in-flight numbers oldest-first, each with a freed flag.
    int m_head, m_tail, m_base;
    int q_num[$];
    bit q_freed[$];
    logic [AW-1:0]        exp_val;
    logic [AW-1:0][W-1:0] exp_num;

    task automatic model_reset();
        m_head = 0;
        m_tail = 0;
        q_num.delete();
        q_freed.delete();
    endtask

    function automatic int age(input int n);
        return (n - m_tail + N) % N;
    endfunction

    task automatic do_reset();
        rst_n          = 1'b0;
        alloc_rdy      = '0;
        commit_val     = '0;
        commit_seq_num = '0;
        squash_val     = 1'b0;
        squash_seq_num = '0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    // Drive one cycle of inputs at the falling edge and predict the combinational outputs.
    task automatic apply(input logic [AW-1:0] rdy, input logic [CW-1:0] cv,
                         input int c0, input int c1, input logic sq, input int s);
        int inf_b;
        @(negedge clk);
        alloc_rdy         = rdy;
        commit_val        = cv;
        commit_seq_num[0] = W'(c0);
        commit_seq_num[1] = W'(c1);
        squash_val        = sq;
        squash_seq_num    = W'(s);
        m_base = sq ? (s + 1) % N : m_head;
        inf_b  = (m_base - m_tail + N) % N;
        for (int k = 0; k < AW; k++) begin
            exp_val[k] = (inf_b + k + 1) <= (N - 1);
            exp_num[k] = W'((m_base + k) % N);
        end
        #1;
    endtask

    // Advance the model across the rising edge using the inputs the DUT sampled.
    task automatic tick();
        int  f, r, keep;
        bit  go;
        @(posedge clk);
        f  = 0;
        go = 1'b1;
        for (int k = 0; k < AW; k++) begin
            go = go & exp_val[k] & alloc_rdy[k];
            if (go) f++;
        end
        if (squash_val) begin
            keep = age(int'(squash_seq_num)) + 1;
            while (q_num.size() > keep) begin
                void'(q_num.pop_back());
                void'(q_freed.pop_back());
            end
        end
        r = 0;
        while (r < RW && r < q_num.size() && q_freed[r]) r++;
        for (int j = 0; j < CW; j++) begin
            if (commit_val[j]) begin
                foreach (q_num[i]) if (q_num[i] == int'(commit_seq_num[j])) q_freed[i] = 1'b1;
            end
        end
        repeat (r) begin
            void'(q_num.pop_front());
            void'(q_freed.pop_front());
        end
        m_tail = (m_tail + r) % N;
        for (int k = 0; k < f; k++) begin
            q_num.push_back((m_base + k) % N);
            q_freed.push_back(1'b0);
        end
        m_head = (m_base + f) % N;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if (alloc_val !== 2'b11 || alloc_seq_num[0] !== 5'd0 || alloc_seq_num[1] !== 5'd1) begin
            n_bad++;
            $display("FAIL reset_outputs: got val=%b num=%0d,%0d want val=11 num=0,1",
                     alloc_val, alloc_seq_num[0], alloc_seq_num[1]);
        end
`ifdef SEQ_NUM_GEN_MULTI_OCC_EN
        n_cmp++;
        if (occupancy !== 6'd0 || full !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_occ: got occ=%0d full=%b want 0/0", occupancy, full);
        end
`endif
    endtask

    task automatic test_basic_alloc();
        for (int c = 0; c < 3; c++) begin
            apply(2'b11, 2'b00, 0, 0, 1'b0, 0);
            n_cmp++;
            if (alloc_val !== 2'b11 || alloc_seq_num[0] !== W'(2*c) || alloc_seq_num[1] !== W'(2*c+1)) begin
                n_bad++;
                $display("FAIL basic_alloc_c%0d: got val=%b num=%0d,%0d want val=11 num=%0d,%0d",
                         c, alloc_val, alloc_seq_num[0], alloc_seq_num[1], 2*c, 2*c+1);
            end
            tick();
        end
        apply(2'b00, 2'b00, 0, 0, 1'b0, 0);
        n_cmp++;
        if (alloc_seq_num[0] !== 5'd6) begin
            n_bad++;
            $display("FAIL basic_head: got %0d want 6", alloc_seq_num[0]);
        end
        tick();
    endtask

    task automatic test_prefix();
        apply(2'b10, 2'b00, 0, 0, 1'b0, 0);
        n_cmp++;
        if (alloc_val !== 2'b11 || alloc_seq_num[0] !== 5'd6) begin
            n_bad++;
            $display("FAIL prefix_offer: got val=%b num0=%0d want val=11 num0=6", alloc_val, alloc_seq_num[0]);
        end
        tick();
        apply(2'b00, 2'b00, 0, 0, 1'b0, 0);
        n_cmp++;
        if (alloc_seq_num[0] !== 5'd6 || alloc_seq_num[1] !== 5'd7) begin
            n_bad++;
            $display("FAIL prefix_head: got num=%0d,%0d want 6,7", alloc_seq_num[0], alloc_seq_num[1]);
        end
        tick();
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int c = 0; c < 40 && q_num.size() < N - 1; c++) begin
            apply(2'b11, 2'b00, 0, 0, 1'b0, 0);
            n_cmp++;
            if (alloc_val !== exp_val || alloc_seq_num !== exp_num) begin
                n_bad++;
                $display("FAIL fill_c%0d: got val=%b num=%h want val=%b num=%h", c, alloc_val, alloc_seq_num, exp_val, exp_num);
            end
            tick();
        end
        apply(2'b11, 2'b00, 0, 0, 1'b0, 0);
        n_cmp++;
        if (alloc_val !== 2'b00) begin
            n_bad++;
            $display("FAIL full_val: got %b want 00", alloc_val);
        end
`ifdef SEQ_NUM_GEN_MULTI_OCC_EN
        n_cmp++;
        if (occupancy !== 6'd31 || full !== 1'b1) begin
            n_bad++;
            $display("FAIL full_occ: got occ=%0d full=%b want 31/1", occupancy, full);
        end
`endif
        tick();
        apply(2'b00, 2'b01, 0, 0, 1'b0, 0);
        tick();
        apply(2'b11, 2'b00, 0, 0, 1'b0, 0);
        n_cmp++;
        if (alloc_val !== 2'b00) begin
            n_bad++;
            $display("FAIL full_after_commit: got %b want 00", alloc_val);
        end
        tick();
        apply(2'b01, 2'b00, 0, 0, 1'b0, 0);
        n_cmp++;
        if (alloc_val !== 2'b01 || alloc_seq_num[0] !== 5'd31) begin
            n_bad++;
            $display("FAIL reopen: got val=%b num0=%0d want val=01 num0=31", alloc_val, alloc_seq_num[0]);
        end
        tick();
        apply(2'b00, 2'b01, 1, 0, 1'b0, 0);
        tick();
        apply(2'b00, 2'b00, 0, 0, 1'b0, 0);
        tick();
        apply(2'b01, 2'b00, 0, 0, 1'b0, 0);
        n_cmp++;
        if (alloc_val !== 2'b01 || alloc_seq_num[0] !== 5'd0) begin
            n_bad++;
            $display("FAIL wrap: got val=%b num0=%0d want val=01 num0=0", alloc_val, alloc_seq_num[0]);
        end
        tick();
    endtask

    task automatic test_squash();
        do_reset();
        repeat (5) begin
            apply(2'b11, 2'b00, 0, 0, 1'b0, 0);
            tick();
        end
        apply(2'b00, 2'b11, 0, 1, 1'b0, 0);
        tick();
        apply(2'b00, 2'b11, 2, 3, 1'b0, 0);
        tick();
        apply(2'b00, 2'b00, 0, 0, 1'b0, 0);
        tick();
        apply(2'b01, 2'b00, 0, 0, 1'b1, 6);
        n_cmp++;
        if (alloc_val[0] !== 1'b1 || alloc_seq_num[0] !== 5'd7 || alloc_val !== exp_val) begin
            n_bad++;
            $display("FAIL squash_bypass: got val=%b num0=%0d want val=%b num0=7", alloc_val, alloc_seq_num[0], exp_val);
        end
        tick();
        apply(2'b00, 2'b00, 0, 0, 1'b0, 0);
        n_cmp++;
        if (alloc_seq_num[0] !== 5'd8) begin
            n_bad++;
            $display("FAIL squash_head: got %0d want 8", alloc_seq_num[0]);
        end
        tick();
    endtask

    // Runs on the state left by test_squash: tail=4, in flight 4..7.
    task automatic test_commit_reclaim();
        for (int c = 0; c < 40 && q_num.size() < N - 1; c++) begin
            apply(2'b11, 2'b00, 0, 0, 1'b0, 0);
            tick();
        end
        apply(2'b00, 2'b11, 5, 4, 1'b0, 0);
        n_cmp++;
        if (alloc_val !== 2'b00) begin
            n_bad++;
            $display("FAIL cr_full: got %b want 00", alloc_val);
        end
        tick();
        apply(2'b00, 2'b00, 0, 0, 1'b0, 0);
        tick();
        apply(2'b11, 2'b00, 0, 0, 1'b0, 0);
        n_cmp++;
        if (alloc_val !== 2'b11 || alloc_seq_num[0] !== 5'd3) begin
            n_bad++;
            $display("FAIL cr_two_reclaimed: got val=%b num0=%0d want val=11 num0=3", alloc_val, alloc_seq_num[0]);
        end
        tick();
        apply(2'b00, 2'b01, 7, 0, 1'b0, 0);
        tick();
        for (int c = 0; c < 2; c++) begin
            apply(2'b00, 2'b00, 0, 0, 1'b0, 0);
            n_cmp++;
            if (alloc_val !== 2'b00) begin
                n_bad++;
                $display("FAIL cr_hole_c%0d: got %b want 00", c, alloc_val);
            end
            tick();
        end
        apply(2'b00, 2'b01, 6, 0, 1'b0, 0);
        tick();
        apply(2'b00, 2'b00, 0, 0, 1'b0, 0);
        tick();
        apply(2'b00, 2'b00, 0, 0, 1'b0, 0);
        n_cmp++;
        if (alloc_val !== 2'b11 || alloc_val !== exp_val) begin
            n_bad++;
            $display("FAIL cr_hole_filled: got %b want 11", alloc_val);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (3) begin
            apply(2'b11, 2'b00, 0, 0, 1'b0, 0);
            tick();
        end
        apply(2'b11, 2'b00, 0, 0, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (alloc_val !== 2'b11 || alloc_seq_num[0] !== 5'd0 || alloc_seq_num[1] !== 5'd1) begin
            n_bad++;
            $display("FAIL async_reset: got val=%b num=%0d,%0d want val=11 num=0,1",
                     alloc_val, alloc_seq_num[0], alloc_seq_num[1]);
        end
        alloc_rdy = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply(2'b11, 2'b00, 0, 0, 1'b0, 0);
        n_cmp++;
        if (alloc_seq_num[0] !== 5'd0 || alloc_seq_num[1] !== 5'd1) begin
            n_bad++;
            $display("FAIL post_reset: got num=%0d,%0d want 0,1", alloc_seq_num[0], alloc_seq_num[1]);
        end
        tick();
    endtask

    task automatic test_random();
        int lim, keep, s, pc;
        logic sq;
        logic [CW-1:0] cv;
        int cn [CW];
        do_reset();
        for (int c = 0; c < 800; c++) begin
            pc   = (c < 400) ? 25 : 75;
            sq   = 1'b0;
            s    = 0;
            keep = q_num.size();
            if (q_num.size() > 0 && $urandom_range(0, 19) == 0) begin
                keep = int'($urandom_range(0, q_num.size() - 1)) + 1;
                s    = q_num[keep-1];
                sq   = 1'b1;
            end
            lim = keep;
            cv  = '0;
            for (int j = 0; j < CW; j++) begin
                cn[j] = 0;
                if (lim > 0 && $urandom_range(0, 99) < pc) begin
                    cv[j] = 1'b1;
                    cn[j] = q_num[$urandom_range(0, lim - 1)];
                end
            end
`ifdef SEQ_NUM_GEN_MULTI_OCC_EN
            #1;
            n_cmp++;
            if (occupancy !== (W+1)'(q_num.size()) || full !== (q_num.size() == N - 1)) begin
                n_bad++;
                $display("FAIL rand_occ_c%0d: got occ=%0d full=%b want occ=%0d", c, occupancy, full, q_num.size());
            end
`endif
            apply(2'($urandom_range(0, 3)), cv, cn[0], cn[1], sq, s);
            n_cmp++;
            if (alloc_val !== exp_val || alloc_seq_num !== exp_num) begin
                n_bad++;
                $display("FAIL rand_c%0d: got val=%b num=%h want val=%b num=%h", c, alloc_val, alloc_seq_num, exp_val, exp_num);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_basic_alloc();
        test_prefix();
        test_full_wrap();
        test_squash();
        test_commit_reclaim();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
